updown_counter_mod: RTL and testbench
=====================================

// Module: updown_counter_mod
// PURPOSE
//  Parametrised loadable up/down modulo counter: next generation of the team's 4-bit loadable counter.
//  Adds width/modulus parameters, direction control, count enable with optional prescaler,
//  wrap/saturate mode, terminal-count and wrap flags.
//  Bus-facing output is tri-stated under output enable.
//  Used as an event/cycle counter and timebase in FPGA designs; drives shared tri-state bus or internal logic.
// PARAMETERS
//  WIDTH     8    counter width in bits (2..32)
//  MODULUS   256  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  SATURATE  0    0: wrap at range ends; 1: hold at range ends
//  PRESCALE  1    counter steps once per PRESCALE enabled cycles (1..65536); 1 = every enabled cycle
// PORTS
//  clk     in   1      single clock, all state updates on rising edge
//  rst     in   1      synchronous, active-high reset
//  ld      in   1      load loadin into counter
//  loadin  in   WIDTH  load value
//  ce      in   1      count enable
//  up      in   1      direction: 1 = increment, 0 = decrement
//  oe      in   1      output enable for dout
//  count   out  WIDTH  registered counter value, always driven
//  dout    out  WIDTH  count when oe=1, else all 'z'
//  tc      out  1      combinational terminal count: (up && count==MODULUS-1) || (!up && count==0)
//  wrap    out  1      registered one-cycle pulse, high in the cycle the wrapped value appears on count
// BEHAVIOUR
//  - Reset: count=0, wrap=0, prescaler phase=0; dout follows oe (z if oe=0); tc evaluates from count=0.
//  - Priority per edge: rst > ld > step > hold.
//  - Load: count <= loadin. If loadin >= MODULUS, count <= MODULUS-1 (clamp).
//    Load clears prescaler phase; wrap=0. Same edge ignores ce.
//  - step = ce && (prescale phase == PRESCALE-1). PRESCALE=1 => step = ce.
//  - Prescaler: advances only when ce=1 and ld=0; returns to 0 after PRESCALE-1; holds when ce=0.
//  - Step up: count+1; at MODULUS-1 -> 0 with wrap=1 (SATURATE=0), or hold with wrap=0 (SATURATE=1).
//  - Step down: count-1; at 0 -> MODULUS-1 with wrap=1 (SATURATE=0), or hold with wrap=0 (SATURATE=1).
//  - wrap is 0 in every cycle that does not follow a wrapping step.
//  - Latency: count/wrap change one edge after the qualifying input; tc and dout are combinational on count/up/oe.
//  - Direction change mid-count takes effect on the next step; prescaler phase is unaffected.
//  - Arithmetic in WIDTH bits; modulo compare against MODULUS-1 sized to WIDTH; no overflow past MODULUS-1.
//  - rst mid-count or during ld: rst wins; state returns to reset values on that edge.
//  - oe affects dout only; the counter keeps running with oe=0.
// STRUCTURE
//  - Shared include counter_defs.vh:
//    - clog2 function
//    - DIR_UP / DIR_DOWN constants
//    - mode constants MODE_WRAP / MODE_SAT
//  - One sub-module: tick_prescaler (params PRESCALE; ports clk, rst, clr, en -> tick).
//    - clr is driven by ld.
//    - PRESCALE=1 reduces tick_prescaler to tick=en.
//  - Top: count register, next-value mux, clamp, tc/wrap logic, tri-state driver.
//  - Elaboration-time check: MODULUS range and PRESCALE >= 1 ($error / fatal in sim).
// TESTING
//  - Reset/load (WIDTH=8,MODULUS=256): rst=1 one cycle -> count=0, wrap=0.
//    ld=1, loadin=8'hA5 -> next cycle count=8'hA5.
//  - Load clamp (MODULUS=10): ld, loadin=15 -> count=9, tc=1 with up=1.
//  - Wrap up/down (MODULUS=10, SATURATE=0, ce=1):
//    - up from 9 -> count=0, wrap=1 for one cycle.
//    - down from 0 -> count=9, wrap=1.
//  - Saturate (MODULUS=10, SATURATE=1): up at 9 for 3 cycles -> count stays 9, wrap=0.
//    Same at 0 going down.
//  - Prescale (PRESCALE=4): ce=1 continuously from 0 -> count increments on every 4th edge.
//    ce=0 for 2 cycles mid-phase delays the step by 2.
//    ld mid-phase restarts the 4-cycle phase.
//  - Priority/tristate:
//    - rst and ld same edge -> count=0.
//    - ld and ce same edge -> count=loadin.
//    - oe=0 -> dout=z while count keeps advancing.
//    - oe=1 -> dout==count.

Source files
------------

// File: rtl/updown_counter_mod_pkg.sv
// Purpose : shared direction/mode constants and a ceil-log2 helper for the up/down counter slice.
// Latency : n/a (package).
// Backpressure: n/a (package).
package updown_counter_mod_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Number of bits needed to hold values 0..v-1 (at least 1).
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < v) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Purpose : control/status bundle of the up/down counter (load, enable, direction, oe, count, flags).
// Latency : n/a (wiring only).
// Backpressure: none; the counter accepts a command every cycle.
// Ports   : master drives ld/loadin/ce/up/oe and observes count/tc/wrap; slave is the counter.
interface updown_counter_mod_if #(
    parameter int WIDTH = 8
);
    logic             ld;
    logic [WIDTH-1:0] loadin;
    logic             ce;
    logic             up;
    logic             oe;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output ld, loadin, ce, up, oe,
        input  count, tc, wrap
    );

    modport slave (
        input  ld, loadin, ce, up, oe,
        output count, tc, wrap
    );
endinterface

// File: rtl/updown_counter_mod_tick_prescaler.sv
// Purpose : divides an enable stream so tick fires once every PRESCALE enabled cycles.
// Latency : tick is combinational on en and the registered phase; phase updates one edge later.
// Backpressure: none; phase holds while en=0, clr restarts the phase at 0.
// Ports   : clk, rst (sync, active-high), clr (phase restart), en (count enable) -> tick.
module tick_prescaler
    import updown_counter_mod_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    if (PRESCALE == 1) begin : g_bypass
        // No division: every enabled cycle is a tick, no state needed.
        logic unused_bypass;
        assign unused_bypass = clk ^ rst ^ clr;
        assign tick          = en;
    end else begin : g_div
        localparam int              PW   = clog2(longint'(PRESCALE));
        localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] phase_q;
        logic [PW-1:0] phase_d;

        always_comb begin
            phase_d = phase_q;
            if (clr) begin
                phase_d = '0;
            end else if (en) begin
                phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_d;
            end
        end

        assign tick = en && (phase_q == LAST);
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Purpose : loadable up/down modulo counter with prescaler, wrap/saturate mode, tc/wrap flags, tri-state dout.
// Latency : count/wrap one edge after ld/ce; tc and dout combinational on count/up/oe.
// Backpressure: none; a command is accepted every cycle, priority rst > ld > step > hold.
// Ports   : clk, rst (sync, active-high), cnt_if (slave: ld/loadin/ce/up/oe in, count/tc/wrap out),
//           dout (count when oe=1, else high impedance).
module updown_counter_mod
    import updown_counter_mod_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int              SATURATE = MODE_WRAP,
    parameter int              PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    updown_counter_mod_if.slave cnt_if,
    output wire [WIDTH-1:0]     dout
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be 2..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("updown_counter_mod: MODULUS must be 2..2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
        $error("updown_counter_mod: PRESCALE must be 1..65536");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic [WIDTH-1:0] load_val;
    logic             step;

    // Load clears the phase; ld also blocks the phase from advancing on that edge.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_if.ld),
        .en   (cnt_if.ce && !cnt_if.ld),
        .tick (step)
    );

    // Out-of-range load values clamp to the top of the range.
    assign load_val = (cnt_if.loadin > MAX_VAL) ? MAX_VAL : cnt_if.loadin;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (cnt_if.ld) begin
            count_d = load_val;
        end else if (step) begin
            if (cnt_if.up == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    if (SATURATE == MODE_WRAP) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    if (SATURATE == MODE_WRAP) begin
                        count_d = MAX_VAL;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cnt_if.count = count_q;
    assign cnt_if.wrap  = wrap_q;
    assign cnt_if.tc    = ((cnt_if.up == DIR_UP)   && (count_q == MAX_VAL)) ||
                          ((cnt_if.up == DIR_DOWN) && (count_q == '0));

    assign dout = cnt_if.oe ? count_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_updown_counter_mod.sv
module tb_updown_counter_mod;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Per-DUT command variables; 0: M256 wrap, 1: M10 wrap, 2: M10 saturate, 3: M10 prescale 4.
    logic       ld_v   [4];
    logic [7:0] li_v   [4];
    logic       ce_v   [4];
    logic       up_v   [4];
    logic       oe_v   [4];
    logic [7:0] cnt_o  [4];
    logic       wrap_o [4];
    logic       tc_o   [4];

    updown_counter_mod_if #(.WIDTH(8)) if0 ();
    updown_counter_mod_if #(.WIDTH(8)) if1 ();
    updown_counter_mod_if #(.WIDTH(8)) if2 ();
    updown_counter_mod_if #(.WIDTH(8)) if3 ();

    wire [7:0] bus0, bus1, bus2, bus3;

    assign if0.ld = ld_v[0]; assign if0.loadin = li_v[0]; assign if0.ce = ce_v[0];
    assign if0.up = up_v[0]; assign if0.oe = oe_v[0];
    assign if1.ld = ld_v[1]; assign if1.loadin = li_v[1]; assign if1.ce = ce_v[1];
    assign if1.up = up_v[1]; assign if1.oe = oe_v[1];
    assign if2.ld = ld_v[2]; assign if2.loadin = li_v[2]; assign if2.ce = ce_v[2];
    assign if2.up = up_v[2]; assign if2.oe = oe_v[2];
    assign if3.ld = ld_v[3]; assign if3.loadin = li_v[3]; assign if3.ce = ce_v[3];
    assign if3.up = up_v[3]; assign if3.oe = oe_v[3];

    assign cnt_o[0] = if0.count; assign wrap_o[0] = if0.wrap; assign tc_o[0] = if0.tc;
    assign cnt_o[1] = if1.count; assign wrap_o[1] = if1.wrap; assign tc_o[1] = if1.tc;
    assign cnt_o[2] = if2.count; assign wrap_o[2] = if2.wrap; assign tc_o[2] = if2.tc;
    assign cnt_o[3] = if3.count; assign wrap_o[3] = if3.wrap; assign tc_o[3] = if3.tc;

    // Another bus agent drives 8'h3C whenever the counter releases the shared bus.
    assign bus0 = oe_v[0] ? 8'bz : 8'h3C;
    assign bus1 = oe_v[1] ? 8'bz : 8'h3C;
    assign bus2 = oe_v[2] ? 8'bz : 8'h3C;
    assign bus3 = oe_v[3] ? 8'bz : 8'h3C;

    updown_counter_mod #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .PRESCALE(1))
        dut0 (.clk(clk), .rst(rst), .cnt_if(if0), .dout(bus0));
    updown_counter_mod #(.WIDTH(8), .MODULUS(10),  .SATURATE(0), .PRESCALE(1))
        dut1 (.clk(clk), .rst(rst), .cnt_if(if1), .dout(bus1));
    updown_counter_mod #(.WIDTH(8), .MODULUS(10),  .SATURATE(1), .PRESCALE(1))
        dut2 (.clk(clk), .rst(rst), .cnt_if(if2), .dout(bus2));
    updown_counter_mod #(.WIDTH(8), .MODULUS(10),  .SATURATE(0), .PRESCALE(4))
        dut3 (.clk(clk), .rst(rst), .cnt_if(if3), .dout(bus3));

    // dmode: 0 = dout not checked, 1 = dout must equal expected count, 2 = dout released (bus reads 3C).
    typedef struct {
        int         id;
        logic [7:0] cnt;
        logic       wrp;
        logic       tcv;
        int         dmode;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic logic [7:0] bus_of(input int id);
        case (id)
            0:       return bus0;
            1:       return bus1;
            2:       return bus2;
            default: return bus3;
        endcase
    endfunction

    // Drive one cycle of stimulus on DUT id and record what it must show after the next edge.
    task automatic vec(input string name, input int id, input logic r, input logic l,
                       input logic [7:0] li, input logic c, input logic u, input logic o,
                       input logic [7:0] ecnt, input logic ewrap, input logic etc, input int dmode);
        exp_t e;
        @(negedge clk);
        rst = r;
        for (int k = 0; k < 4; k++) begin
            ld_v[k] = 1'b0;
            ce_v[k] = 1'b0;
        end
        ld_v[id] = l;
        li_v[id] = li;
        ce_v[id] = c;
        up_v[id] = u;
        oe_v[id] = o;
        e.id = id; e.cnt = ecnt; e.wrp = ewrap; e.tcv = etc; e.dmode = dmode; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: the counter presents a result every cycle; pop one expectation per edge.
    initial begin
        exp_t       e;
        logic [9:0] got, req;
        logic [7:0] d, dw;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {cnt_o[e.id], wrap_o[e.id], tc_o[e.id]};
                req = {e.cnt, e.wrp, e.tcv};
                checks++;
                if (got === req) passes++;
                else $display("FAIL %s: count/wrap/tc got %h/%b/%b need %h/%b/%b", e.name,
                              got[9:2], got[1], got[0], req[9:2], req[1], req[0]);
                if (e.dmode != 0) begin
                    d  = bus_of(e.id);
                    dw = (e.dmode == 1) ? e.cnt : 8'h3C;
                    checks++;
                    if (d === dw) passes++;
                    else $display("FAIL %s_dout: dout got %h need %h", e.name, d, dw);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            ld_v[k] = 1'b0; li_v[k] = 8'h00; ce_v[k] = 1'b0; up_v[k] = 1'b1; oe_v[k] = 1'b0;
        end

        //  name        id rst ld  loadin ce up oe  count wrap tc dmode
        vec("rst",       0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 2);
        vec("rst_dn",    0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
        vec("load_a5",   0, 0, 1, 8'hA5, 0, 1, 0, 8'hA5, 0, 0, 0);
        vec("step_up",   0, 0, 0, 8'h00, 1, 1, 0, 8'hA6, 0, 0, 0);
        vec("rst_ld",    0, 1, 1, 8'h55, 1, 1, 0, 8'h00, 0, 0, 0);
        vec("ld_ce",     0, 0, 1, 8'h10, 1, 1, 0, 8'h10, 0, 0, 0);
        vec("oe_on",     0, 0, 0, 8'h00, 1, 1, 1, 8'h11, 0, 0, 1);
        vec("oe_off",    0, 0, 0, 8'h00, 1, 1, 0, 8'h12, 0, 0, 2);
        vec("oe_off2",   0, 0, 0, 8'h00, 1, 1, 0, 8'h13, 0, 0, 2);
        vec("oe_back",   0, 0, 0, 8'h00, 0, 1, 1, 8'h13, 0, 0, 1);
        vec("ld_ff",     0, 0, 1, 8'hFF, 0, 1, 1, 8'hFF, 0, 1, 1);
        vec("wrap256",   0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 1, 0, 1);

        vec("clamp",     1, 0, 1, 8'd15, 0, 1, 0, 8'd9,  0, 1, 0);
        vec("wrap_up",   1, 0, 0, 8'd0,  1, 1, 0, 8'd0,  1, 0, 0);
        vec("after_up",  1, 0, 0, 8'd0,  1, 1, 0, 8'd1,  0, 0, 0);
        vec("ld_zero",   1, 0, 1, 8'd0,  0, 0, 0, 8'd0,  0, 1, 0);
        vec("wrap_dn",   1, 0, 0, 8'd0,  1, 0, 0, 8'd9,  1, 0, 0);
        vec("after_dn",  1, 0, 0, 8'd0,  1, 0, 0, 8'd8,  0, 0, 0);
        vec("dir_flip",  1, 0, 0, 8'd0,  1, 1, 0, 8'd9,  0, 1, 0);

        vec("sat_ld9",   2, 0, 1, 8'd9,  0, 1, 0, 8'd9,  0, 1, 0);
        for (int i = 0; i < 3; i++)
            vec("sat_up",  2, 0, 0, 8'd0,  1, 1, 0, 8'd9,  0, 1, 0);
        vec("sat_ld0",   2, 0, 1, 8'd0,  0, 0, 0, 8'd0,  0, 1, 0);
        for (int i = 0; i < 3; i++)
            vec("sat_dn",  2, 0, 0, 8'd0,  1, 0, 0, 8'd0,  0, 1, 0);
        vec("sat_leave", 2, 0, 0, 8'd0,  1, 1, 0, 8'd1,  0, 0, 0);

        vec("pre_ld",    3, 0, 1, 8'd0,  0, 1, 0, 8'd0,  0, 0, 0);
        for (int i = 1; i <= 8; i++)
            vec("pre_run", 3, 0, 0, 8'd0,  1, 1, 0, 8'(i / 4), 0, 0, 0);
        vec("pre_ph1",   3, 0, 0, 8'd0,  1, 1, 0, 8'd2,  0, 0, 0);
        vec("pre_hold",  3, 0, 0, 8'd0,  0, 1, 0, 8'd2,  0, 0, 0);
        vec("pre_hold",  3, 0, 0, 8'd0,  0, 1, 0, 8'd2,  0, 0, 0);
        vec("pre_ph2",   3, 0, 0, 8'd0,  1, 1, 0, 8'd2,  0, 0, 0);
        vec("pre_ph3",   3, 0, 0, 8'd0,  1, 1, 0, 8'd2,  0, 0, 0);
        vec("pre_delay", 3, 0, 0, 8'd0,  1, 1, 0, 8'd3,  0, 0, 0);
        vec("pre_mid",   3, 0, 0, 8'd0,  1, 1, 0, 8'd3,  0, 0, 0);
        vec("pre_mid",   3, 0, 0, 8'd0,  1, 1, 0, 8'd3,  0, 0, 0);
        vec("pre_ldmid", 3, 0, 1, 8'd5,  1, 1, 0, 8'd5,  0, 0, 0);
        for (int i = 0; i < 3; i++)
            vec("pre_rest",3, 0, 0, 8'd0,  1, 1, 0, 8'd5,  0, 0, 0);
        vec("pre_step",  3, 0, 0, 8'd0,  1, 1, 0, 8'd6,  0, 0, 0);

        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            ld_v[k] = 1'b0;
            ce_v[k] = 1'b0;
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: pending expectations got %0d need 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
